// File: rtl/alu_issue_if.sv
// Handshake, writeback and issued-bundle signals between the decode/issue stage and its neighbours.
// The stage takes the slave modport and its environment takes the master modport.
interface alu_issue_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [XLEN-1:0] in_pc;

  logic            wb_en;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_data;

  logic            out_valid;
  logic            out_ready;
  logic [2:0]      out_funct3;
  logic            out_mod;
  logic [XLEN-1:0] out_val1;
  logic [XLEN-1:0] out_val2;
  logic [4:0]      out_rd;
  logic            out_we;
  logic            out_illegal;

  modport master (
    output in_valid, in_instr, in_pc, wb_en, wb_rd, wb_data, out_ready,
    input  in_ready, out_valid, out_funct3, out_mod, out_val1, out_val2,
           out_rd, out_we, out_illegal
  );

  modport slave (
    input  in_valid, in_instr, in_pc, wb_en, wb_rd, wb_data, out_ready,
    output in_ready, out_valid, out_funct3, out_mod, out_val1, out_val2,
           out_rd, out_we, out_illegal
  );
endinterface

// File: rtl/alu_issue.sv
// RV32I decode/operand-issue stage: 1-cycle registered bundle, in_ready = !out_valid || out_ready.
// Optional ALU_ISSUE_BYPASS_EN forwards a same-edge writeback into the operands being read.
module alu_issue #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  alu_issue_if.slave  bus
);
  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;

  logic [XLEN-1:0] regs [NREGS];

  logic [6:0]      opcode;
  logic [6:0]      funct7;
  logic [2:0]      f3;
  logic [4:0]      rs1;
  logic [4:0]      rs2;
  logic [4:0]      rd;
  logic [XLEN-1:0] imm_i;
  logic [XLEN-1:0] imm_u;
  logic [XLEN-1:0] rv1;
  logic [XLEN-1:0] rv2;

  logic [2:0]      d_funct3;
  logic            d_mod;
  logic [XLEN-1:0] d_val1;
  logic [XLEN-1:0] d_val2;
  logic [4:0]      d_rd;
  logic            d_we;
  logic            d_illegal;
  logic            accept;

  assign opcode = bus.in_instr[6:0];
  assign rd     = bus.in_instr[11:7];
  assign f3     = bus.in_instr[14:12];
  assign rs1    = bus.in_instr[19:15];
  assign rs2    = bus.in_instr[24:20];
  assign funct7 = bus.in_instr[31:25];
  assign imm_i  = {{20{bus.in_instr[31]}}, bus.in_instr[31:20]};
  assign imm_u  = {bus.in_instr[31:12], 12'h000};

  assign bus.in_ready = !bus.out_valid || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (bus.wb_en && bus.wb_rd != 5'd0) begin
      regs[bus.wb_rd] <= bus.wb_data;
    end
  end

  always_comb begin
    rv1 = (rs1 == 5'd0) ? '0 : regs[rs1];
    rv2 = (rs2 == 5'd0) ? '0 : regs[rs2];
`ifdef ALU_ISSUE_BYPASS_EN
    if (bus.wb_en && bus.wb_rd != 5'd0 && bus.wb_rd == rs1) rv1 = bus.wb_data;
    if (bus.wb_en && bus.wb_rd != 5'd0 && bus.wb_rd == rs2) rv2 = bus.wb_data;
`endif
  end

  always_comb begin
    d_funct3  = f3;
    d_mod     = 1'b0;
    d_val1    = '0;
    d_val2    = '0;
    d_illegal = 1'b0;
    case (opcode)
      OPC_OP: begin
        d_val1 = rv1;
        d_val2 = rv2;
        if (funct7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101)) d_mod = 1'b1;
        else if (funct7 != 7'b0000000) d_illegal = 1'b1;
      end
      OPC_OPIMM: begin
        d_val1 = rv1;
        d_val2 = imm_i;
        // Shift-immediates carry their SRA/SRL selector in the upper immediate bits.
        if (f3 == 3'b001 && funct7 != 7'b0000000) d_illegal = 1'b1;
        if (f3 == 3'b101) begin
          if (funct7 == 7'b0100000) d_mod = 1'b1;
          else if (funct7 != 7'b0000000) d_illegal = 1'b1;
        end
      end
      OPC_LUI: begin
        d_funct3 = 3'b000;
        d_val2   = imm_u;
      end
      OPC_AUIPC: begin
        d_funct3 = 3'b000;
        d_val1   = bus.in_pc;
        d_val2   = imm_u;
      end
      default: d_illegal = 1'b1;
    endcase
    if (d_illegal) begin
      d_funct3 = 3'b000;
      d_mod    = 1'b0;
      d_val1   = '0;
      d_val2   = '0;
    end
    d_rd = d_illegal ? 5'd0 : rd;
    d_we = !d_illegal && (rd != 5'd0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_valid   <= 1'b0;
      bus.out_funct3  <= 3'b000;
      bus.out_mod     <= 1'b0;
      bus.out_val1    <= '0;
      bus.out_val2    <= '0;
      bus.out_rd      <= 5'd0;
      bus.out_we      <= 1'b0;
      bus.out_illegal <= 1'b0;
    end else if (accept) begin
      bus.out_valid   <= 1'b1;
      bus.out_funct3  <= d_funct3;
      bus.out_mod     <= d_mod;
      bus.out_val1    <= d_val1;
      bus.out_val2    <= d_val2;
      bus.out_rd      <= d_rd;
      bus.out_we      <= d_we;
      bus.out_illegal <= d_illegal;
    end else if (bus.out_ready) begin
      bus.out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue: decode of each opcode class, stall/throughput and reset behaviour.
// Expected values are hand-computed from the instruction encodings.
module tb_alu_issue;
  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  alu_issue_if #(.XLEN(32)) bus ();

  alu_issue #(.XLEN(32), .NREGS(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_bundle(input string tag, input logic [2:0] f3, input logic md,
                            input logic [31:0] v1, input logic [31:0] v2, input logic [4:0] rd,
                            input logic we, input logic ill);
    chk({tag, ".valid"},   {31'd0, bus.out_valid},   32'd1);
    chk({tag, ".funct3"},  {29'd0, bus.out_funct3},  {29'd0, f3});
    chk({tag, ".mod"},     {31'd0, bus.out_mod},     {31'd0, md});
    chk({tag, ".val1"},    bus.out_val1,             v1);
    chk({tag, ".val2"},    bus.out_val2,             v2);
    chk({tag, ".rd"},      {27'd0, bus.out_rd},      {27'd0, rd});
    chk({tag, ".we"},      {31'd0, bus.out_we},      {31'd0, we});
    chk({tag, ".illegal"}, {31'd0, bus.out_illegal}, {31'd0, ill});
  endtask

  task automatic issue(input logic [31:0] instr, input logic [31:0] pc);
    bus.in_instr = instr;
    bus.in_pc    = pc;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic wb(input logic [4:0] r, input logic [31:0] d);
    bus.wb_en   = 1'b1;
    bus.wb_rd   = r;
    bus.wb_data = d;
    tick();
    bus.wb_en   = 1'b0;
  endtask

  initial begin
    errors        = 0;
    checks        = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_instr  = 32'h0;
    bus.in_pc     = 32'h0;
    bus.wb_en     = 1'b0;
    bus.wb_rd     = 5'd0;
    bus.wb_data   = 32'h0;
    bus.out_ready = 1'b1;
    #12;
    chk("rst.valid",    {31'd0, bus.out_valid},   32'd0);
    chk("rst.rd",       {27'd0, bus.out_rd},      32'd0);
    chk("rst.illegal",  {31'd0, bus.out_illegal}, 32'd0);
    chk("rst.in_ready", {31'd0, bus.in_ready},    32'd1);
    rst_n = 1'b1;
    tick();

    issue(32'h00500093, 32'h0);                                    // ADDI x1,x0,5
    chk_bundle("addi", 3'b000, 1'b0, 32'd0, 32'd5, 5'd1, 1'b1, 1'b0);

    wb(5'd1, 32'd7);
    chk("idle.valid", {31'd0, bus.out_valid}, 32'd0);
    wb(5'd2, 32'd3);
    wb(5'd0, 32'hDEAD);                                            // x0 must stay zero

    issue(32'h402081B3, 32'h0);                                    // SUB x3,x1,x2
    chk_bundle("sub", 3'b000, 1'b1, 32'd7, 32'd3, 5'd3, 1'b1, 1'b0);

    issue(32'h4030D293, 32'h0);                                    // SRAI x5,x1,3
    chk("srai.funct3", {29'd0, bus.out_funct3}, 32'd5);
    chk("srai.mod",    {31'd0, bus.out_mod},    32'd1);
    chk("srai.val1",   bus.out_val1,            32'd7);
    chk("srai.shamt",  {27'd0, bus.out_val2[4:0]}, 32'd3);
    chk("srai.rd",     {27'd0, bus.out_rd},     32'd5);

    issue(32'h123453B7, 32'h0);                                    // LUI x7,0x12345
    chk_bundle("lui", 3'b000, 1'b0, 32'd0, 32'h12345000, 5'd7, 1'b1, 1'b0);

    issue(32'h12345397, 32'h100);                                  // AUIPC x7,0x12345
    chk_bundle("auipc", 3'b000, 1'b0, 32'h100, 32'h12345000, 5'd7, 1'b1, 1'b0);

    issue(32'h00000000, 32'h0);
    chk_bundle("zero_instr", 3'b000, 1'b0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b1);

    issue(32'h00208033, 32'h0);                                    // ADD x0,x1,x2
    chk_bundle("add_x0", 3'b000, 1'b0, 32'd7, 32'd3, 5'd0, 1'b0, 1'b0);

    issue(32'h02208233, 32'h0);                                    // funct7=0000001 is not handled here
    chk("op_f7.illegal", {31'd0, bus.out_illegal}, 32'd1);
    chk("op_f7.we",      {31'd0, bus.out_we},      32'd0);

    issue(32'h4010D293, 32'h0);                                    // SRLI form with funct7=0100000 ok, f3=101
    chk("srai1.mod", {31'd0, bus.out_mod}, 32'd1);
    issue(32'h40109293, 32'h0);                                    // SLLI with funct7=0100000 is illegal
    chk("slli_bad.illegal", {31'd0, bus.out_illegal}, 32'd1);

    // Backpressure: hold ADDI x6 for three stalled cycles, then drain and take ADDI x8.
    issue(32'h00900313, 32'h0);                                    // ADDI x6,x0,9
    bus.out_ready = 1'b0;
    bus.in_instr  = 32'h00B00413;                                  // ADDI x8,x0,11
    bus.in_valid  = 1'b1;
    #1;
    chk("stall.in_ready", {31'd0, bus.in_ready}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall.valid",    {31'd0, bus.out_valid}, 32'd1);
      chk("stall.rd",       {27'd0, bus.out_rd},    32'd6);
      chk("stall.val2",     bus.out_val2,           32'd9);
      chk("stall.in_ready", {31'd0, bus.in_ready},  32'd0);
    end
    bus.out_ready = 1'b1;
    #1;
    chk("drain.in_ready", {31'd0, bus.in_ready}, 32'd1);
    tick();
    bus.in_valid = 1'b0;
    chk_bundle("after_stall", 3'b000, 1'b0, 32'd0, 32'd11, 5'd8, 1'b1, 1'b0);
    tick();
    chk("no_dup.valid", {31'd0, bus.out_valid}, 32'd0);

    // Accept ADD x4,x1,x2 on the same edge that writes x1.
    bus.wb_en   = 1'b1;
    bus.wb_rd   = 5'd1;
    bus.wb_data = 32'hAA;
    issue(32'h00208233, 32'h0);
    bus.wb_en   = 1'b0;
`ifdef ALU_ISSUE_BYPASS_EN
    chk("same_edge.val1", bus.out_val1, 32'hAA);
`else
    chk("same_edge.val1", bus.out_val1, 32'd7);
`endif
    chk("same_edge.val2", bus.out_val2, 32'd3);
    issue(32'h00208233, 32'h0);
    chk("after_wb.val1", bus.out_val1, 32'hAA);

    // Reset asserted mid-stall clears the bundle at once and wipes the register file.
    bus.out_ready = 1'b0;
    issue(32'h00208233, 32'h0);
    chk("pre_rst.valid", {31'd0, bus.out_valid}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst.valid", {31'd0, bus.out_valid}, 32'd0);
    chk("mid_rst.val1",  bus.out_val1,           32'd0);
    chk("mid_rst.rd",    {27'd0, bus.out_rd},    32'd0);
    #3;
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    issue(32'h00208233, 32'h0);
    chk_bundle("post_rst", 3'b000, 1'b0, 32'd0, 32'd0, 5'd4, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end
endmodule
